// File: rtl/gated_bus_mux_if.sv
// gated_bus_mux_if
//   Bundles the source, gate and status signals of gated_bus_mux so the
//   mux and its users connect through a single port.
// Parameters
//   WIDTH  data width of each source and of the bus
//   N      number of sources / gates
//   CNT_W  width of the conflict counter
// Signals
//   din        N*WIDTH  flattened sources, source i = din[i*WIDTH +: WIDTH]
//   gate       N        one-hot drive enables
//   hold       1        freeze keeper and last_src
//   clr_err    1        clear err_sticky / err_count
//   bus        WIDTH    bus value
//   bus_valid  1        a source drove the bus
//   conflict   1        more than one gate asserted
//   err_sticky 1        conflict seen since reset / clr_err
//   err_count  CNT_W    saturating conflict count
//   last_src   clog2(N) index of most recent driving source
// Modports: master drives sources and gates, slave is the mux.
interface gated_bus_mux_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       gate;
  logic               hold;
  logic               clr_err;
  logic [WIDTH-1:0]   bus;
  logic               bus_valid;
  logic               conflict;
  logic               err_sticky;
  logic [CNT_W-1:0]   err_count;
  logic [SEL_W-1:0]   last_src;

  modport master (
    output din, gate, hold, clr_err,
    input  bus, bus_valid, conflict, err_sticky, err_count, last_src
  );

  modport slave (
    input  din, gate, hold, clr_err,
    output bus, bus_valid, conflict, err_sticky, err_count, last_src
  );
endinterface

// File: rtl/gated_bus_mux.sv
// gated_bus_mux
//   N-input one-hot gated bus multiplexer with a bus keeper, optional output
//   register and multi-driver conflict detection (sticky flag plus saturating
//   counter). The lowest-index asserted gate wins when several are set.
// Parameters
//   WIDTH       data width of each source and the bus
//   N           number of sources (N >= 2)
//   REGISTERED  1: bus/valid/conflict/last_src registered (1-cycle latency)
//               0: those outputs combinational; keeper still registered
//   CNT_W       conflict counter width
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bif    gated_bus_mux_if.slave: din, gate, hold, clr_err in;
//          bus, bus_valid, conflict, err_sticky, err_count, last_src out
module gated_bus_mux #(
  parameter int WIDTH      = 16,
  parameter int N          = 4,
  parameter int REGISTERED = 1,
  parameter int CNT_W      = 8
) (
  input logic             clk,
  input logic             reset,
  gated_bus_mux_if.slave  bif
);
  localparam int SEL_W = $clog2(N);

  function automatic logic [SEL_W-1:0] lowest_set(input logic [N-1:0] g);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (g[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [N-1:0] g);
    return |(g & (g - N'(1)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [SEL_W-1:0] sel;
  logic             drive;
  logic             multi;
  logic             take;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    sel      = lowest_set(bif.gate);
    drive    = |bif.gate;
    multi    = more_than_one(bif.gate);
    take     = drive & ~bif.hold;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) sel_data = bif.din[i*WIDTH +: WIDTH];
    end
  end

  // Stage p0 -> p1: keeper, source index and error bookkeeping.
  logic [WIDTH-1:0] keeper_p1;
  logic [SEL_W-1:0] last_src_p1;
  logic             err_sticky_q;
  logic [CNT_W-1:0] err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      keeper_p1    <= '0;
      last_src_p1  <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      if (take) begin
        keeper_p1   <= sel_data;
        last_src_p1 <= sel;
      end
      // A conflict in the same cycle as clr_err counts as the first new event.
      if (multi) begin
        err_sticky_q <= 1'b1;
        err_count_q  <= bif.clr_err ? CNT_W'(1) : sat_inc(err_count_q);
      end else if (bif.clr_err) begin
        err_sticky_q <= 1'b0;
        err_count_q  <= '0;
      end
    end
  end

  assign bif.err_sticky = err_sticky_q;
  assign bif.err_count  = err_count_q;

  generate
    if (REGISTERED != 0) begin : g_reg
      logic vld_p1;
      logic conflict_p1;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1      <= 1'b0;
          conflict_p1 <= 1'b0;
        end else begin
          vld_p1      <= take;
          conflict_p1 <= multi;
        end
      end

      assign bif.bus       = keeper_p1;
      assign bif.bus_valid = vld_p1;
      assign bif.conflict  = conflict_p1;
      assign bif.last_src  = last_src_p1;
    end else begin : g_comb
      // Reset masks the live path so outputs read zero while it is held.
      logic live;
      assign live          = take & ~reset;
      assign bif.bus       = live ? sel_data : keeper_p1;
      assign bif.bus_valid = live;
      assign bif.conflict  = multi & ~reset;
      assign bif.last_src  = live ? sel : last_src_p1;
    end
  endgenerate
endmodule

// File: tb/tb_gated_bus_mux.sv
module tb_gated_bus_mux;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gated_bus_mux_if #(.WIDTH(16), .N(4), .CNT_W(8)) ir ();
  gated_bus_mux_if #(.WIDTH(16), .N(4), .CNT_W(8)) ic ();
  gated_bus_mux_if #(.WIDTH(8),  .N(3), .CNT_W(4)) i3 ();

  gated_bus_mux #(.WIDTH(16), .N(4), .REGISTERED(1), .CNT_W(8)) dut_r (
    .clk(clk), .reset(reset), .bif(ir));
  gated_bus_mux #(.WIDTH(16), .N(4), .REGISTERED(0), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .bif(ic));
  gated_bus_mux #(.WIDTH(8),  .N(3), .REGISTERED(1), .CNT_W(4)) dut_3 (
    .clk(clk), .reset(reset), .bif(i3));

  function automatic logic [19:0] st_r();
    return {ir.bus, ir.bus_valid, ir.conflict, ir.last_src};
  endfunction
  function automatic logic [19:0] st_c();
    return {ic.bus, ic.bus_valid, ic.conflict, ic.last_src};
  endfunction
  function automatic logic [11:0] st_3();
    return {i3.bus, i3.bus_valid, i3.conflict, i3.last_src};
  endfunction
  function automatic logic [8:0] err_r();
    return {ir.err_sticky, ir.err_count};
  endfunction
  function automatic logic [8:0] err_c();
    return {ic.err_sticky, ic.err_count};
  endfunction
  function automatic logic [4:0] err_3();
    return {i3.err_sticky, i3.err_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [63:0] d, input logic [3:0] g,
                     input logic h, input logic c);
    ir.din = d; ir.gate = g; ir.hold = h; ir.clr_err = c;
    ic.din = d; ic.gate = g; ic.hold = h; ic.clr_err = c;
  endtask

  task automatic put3(input logic [23:0] d, input logic [2:0] g);
    i3.din = d; i3.gate = g; i3.hold = 1'b0; i3.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    reset = 1'b1;
    put(64'h0, 4'b0000, 1'b0, 1'b0);
    put3(24'h0, 3'b000);
    tick();
    reset = 1'b0;
    put(64'h0, 4'b0011, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    put({$urandom, $urandom}, 4'($urandom), 1'($urandom), 1'($urandom));
    put3(24'($urandom), 3'($urandom));
    tick();
    e = 20'h0;
    vectors++;
    if (st_r() !== e) begin
      miscompares++; $display("FAIL reset_reg_bus got=%h want=%h", st_r(), e);
    end
    vectors++;
    if (err_r() !== 9'h0) begin
      miscompares++; $display("FAIL reset_reg_err got=%h want=000", err_r());
    end
    vectors++;
    if (st_c() !== e) begin
      miscompares++; $display("FAIL reset_comb_bus got=%h want=%h", st_c(), e);
    end
    vectors++;
    if (err_c() !== 9'h0) begin
      miscompares++; $display("FAIL reset_comb_err got=%h want=000", err_c());
    end
    vectors++;
    if ({st_3(), err_3()} !== 17'h0) begin
      miscompares++; $display("FAIL reset_n3 got=%h want=00000", {st_3(), err_3()});
    end
    put3(24'h0, 3'b000);
  endtask

  task automatic test_onehot();
    logic [19:0] e;
    reset = 1'b0;
    put({16'h4444, 16'h3A5C, 16'h2222, 16'h1111}, 4'b0100, 1'b0, 1'b0);
    e = {16'h3A5C, 1'b1, 1'b0, 2'd2};
    #1;
    vectors++;
    if (st_c() !== e) begin
      miscompares++; $display("FAIL onehot_comb got=%h want=%h", st_c(), e);
    end
    tick();
    vectors++;
    if (st_r() !== e) begin
      miscompares++; $display("FAIL onehot_reg got=%h want=%h", st_r(), e);
    end
    vectors++;
    if (err_r() !== 9'h0) begin
      miscompares++; $display("FAIL onehot_err got=%h want=000", err_r());
    end
  endtask

  task automatic test_keeper();
    logic [19:0] e;
    put({4{16'hFFFF}}, 4'b0000, 1'b0, 1'b0);
    e = {16'h3A5C, 1'b0, 1'b0, 2'd2};
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (st_c() !== e) begin
        miscompares++; $display("FAIL keeper_comb[%0d] got=%h want=%h", k, st_c(), e);
      end
      tick();
      vectors++;
      if (st_r() !== e) begin
        miscompares++; $display("FAIL keeper_reg[%0d] got=%h want=%h", k, st_r(), e);
      end
    end
  endtask

  task automatic test_conflict();
    logic [19:0] e;
    put({16'h3333, 16'h2222, 16'h1111, 16'h0000}, 4'b1010, 1'b0, 1'b0);
    e = {16'h1111, 1'b1, 1'b1, 2'd1};
    #1;
    vectors++;
    if ({st_c(), err_c()} !== {e, 9'h000}) begin
      miscompares++; $display("FAIL conflict_comb got=%h want=%h", {st_c(), err_c()}, {e, 9'h000});
    end
    tick();
    vectors++;
    if ({st_r(), err_r()} !== {e, 1'b1, 8'd1}) begin
      miscompares++; $display("FAIL conflict_reg got=%h want=%h", {st_r(), err_r()}, {e, 1'b1, 8'd1});
    end
    vectors++;
    if (err_c() !== {1'b1, 8'd1}) begin
      miscompares++; $display("FAIL conflict_comb_err got=%h want=101", err_c());
    end
    repeat (299) tick();
    vectors++;
    if (err_r() !== {1'b1, 8'd255}) begin
      miscompares++; $display("FAIL saturate_reg got=%h want=1ff", err_r());
    end
    repeat (5) tick();
    vectors++;
    if (err_r() !== {1'b1, 8'd255}) begin
      miscompares++; $display("FAIL saturate_hold_reg got=%h want=1ff", err_r());
    end
    vectors++;
    if (err_c() !== {1'b1, 8'd255}) begin
      miscompares++; $display("FAIL saturate_hold_comb got=%h want=1ff", err_c());
    end
  endtask

  task automatic test_clear_collision();
    logic [63:0] d;
    d = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    put(d, 4'b0000, 1'b0, 1'b1);
    tick();
    vectors++;
    if ({err_r(), err_c()} !== 18'h0) begin
      miscompares++; $display("FAIL clr_from_max got=%h want=00000", {err_r(), err_c()});
    end
    put(d, 4'b0011, 1'b0, 1'b0);
    repeat (7) tick();
    vectors++;
    if (err_r() !== {1'b1, 8'd7}) begin
      miscompares++; $display("FAIL count_to_7 got=%h want=107", err_r());
    end
    put(d, 4'b0011, 1'b0, 1'b1);
    tick();
    vectors++;
    if ({err_r(), err_c()} !== {1'b1, 8'd1, 1'b1, 8'd1}) begin
      miscompares++; $display("FAIL clr_collision got=%h want=%h", {err_r(), err_c()}, {1'b1, 8'd1, 1'b1, 8'd1});
    end
    put(d, 4'b0000, 1'b0, 1'b1);
    tick();
    vectors++;
    if ({err_r(), err_c()} !== 18'h0) begin
      miscompares++; $display("FAIL clr_alone got=%h want=00000", {err_r(), err_c()});
    end
    put(d, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_hold_reset();
    logic [19:0] e;
    logic [63:0] d;
    put({16'h4444, 16'h3A5C, 16'h2222, 16'h1111}, 4'b0100, 1'b0, 1'b0);
    tick();
    d = {16'h4444, 16'h3A5C, 16'h2222, 16'hBEEF};
    put(d, 4'b0001, 1'b1, 1'b0);
    e = {16'h3A5C, 1'b0, 1'b0, 2'd2};
    #1;
    vectors++;
    if (st_c() !== e) begin
      miscompares++; $display("FAIL hold_comb got=%h want=%h", st_c(), e);
    end
    tick();
    vectors++;
    if (st_r() !== e) begin
      miscompares++; $display("FAIL hold_reg got=%h want=%h", st_r(), e);
    end
    vectors++;
    if (st_c() !== e) begin
      miscompares++; $display("FAIL hold_keeper_comb got=%h want=%h", st_c(), e);
    end
    put(d, 4'b0011, 1'b1, 1'b0);
    e = {16'h3A5C, 1'b0, 1'b1, 2'd2};
    #1;
    vectors++;
    if (st_c() !== e) begin
      miscompares++; $display("FAIL hold_conflict_comb got=%h want=%h", st_c(), e);
    end
    tick();
    vectors++;
    if ({st_r(), err_r()} !== {e, 1'b1, 8'd1}) begin
      miscompares++; $display("FAIL hold_conflict_reg got=%h want=%h", {st_r(), err_r()}, {e, 1'b1, 8'd1});
    end
    reset = 1'b1;
    put(d, 4'b0110, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({st_r(), err_r()} !== 29'h0) begin
      miscompares++; $display("FAIL midop_reset_reg got=%h want=0", {st_r(), err_r()});
    end
    vectors++;
    if ({st_c(), err_c()} !== 29'h0) begin
      miscompares++; $display("FAIL midop_reset_comb got=%h want=0", {st_c(), err_c()});
    end
    reset = 1'b0;
    put(d, 4'b0000, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({st_r(), err_r()} !== 29'h0) begin
      miscompares++; $display("FAIL post_reset_reg got=%h want=0", {st_r(), err_r()});
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e;
    logic [1:0]  src;
    for (int k = 0; k < 6; k++) begin
      src = 2'(k % 4);
      put({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b0001 << src, 1'b0, 1'b0);
      e = {16'(16'h1111 * (src + 1)), 1'b1, 1'b0, src};
      #1;
      vectors++;
      if (st_c() !== e) begin
        miscompares++; $display("FAIL b2b_comb[%0d] got=%h want=%h", k, st_c(), e);
      end
      tick();
      vectors++;
      if (st_r() !== e) begin
        miscompares++; $display("FAIL b2b_reg[%0d] got=%h want=%h", k, st_r(), e);
      end
    end
    put(64'h0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_non_pow2();
    logic [11:0] e;
    put3({8'hC3, 8'hB2, 8'hA1}, 3'b100);
    tick();
    e = {8'hC3, 1'b1, 1'b0, 2'd2};
    vectors++;
    if (st_3() !== e) begin
      miscompares++; $display("FAIL n3_top_src got=%h want=%h", st_3(), e);
    end
    put3({8'hC3, 8'hB2, 8'hA1}, 3'b110);
    tick();
    e = {8'hB2, 1'b1, 1'b1, 2'd1};
    vectors++;
    if ({st_3(), err_3()} !== {e, 1'b1, 4'd1}) begin
      miscompares++; $display("FAIL n3_conflict got=%h want=%h", {st_3(), err_3()}, {e, 1'b1, 4'd1});
    end
    repeat (19) tick();
    vectors++;
    if (err_3() !== {1'b1, 4'd15}) begin
      miscompares++; $display("FAIL n3_saturate got=%h want=1f", err_3());
    end
    put3({8'hC3, 8'hB2, 8'hA1}, 3'b000);
    tick();
    e = {8'hB2, 1'b0, 1'b0, 2'd1};
    vectors++;
    if ({st_3(), err_3()} !== {e, 1'b1, 4'd15}) begin
      miscompares++; $display("FAIL n3_keeper got=%h want=%h", {st_3(), err_3()}, {e, 1'b1, 4'd15});
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_keeper();
    test_conflict();
    test_clear_collision();
    test_hold_reset();
    test_back_to_back();
    test_non_pow2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
